// File: rtl/sprite_blitter.sv
// Copies a 16x16 tile from a 256x256 4-bit spritesheet into a linear framebuffer.
// Index 0 is transparent. Off-screen pixels are dropped rather than wrapped.
module sprite_blitter #(
  parameter int FB_W = 640,
  parameter int FB_H = 480
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [3:0]  src_col,
  input  logic [3:0]  src_row,
  input  logic [9:0]  dst_x,
  input  logic [9:0]  dst_y,
  output logic [15:0] sheet_addr,
  input  logic [3:0]  sheet_data,
  output logic [18:0] fb_addr,
  output logic [3:0]  fb_data,
  output logic        fb_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        drain_cnt;

  logic [3:0]  col_q;
  logic [3:0]  row_q;
  logic [9:0]  dx_q;
  logic [9:0]  dy_q;

  logic [7:0]  idx_p0;
  logic [7:0]  idx_nxt;
  logic        vld_p1;
  logic [10:0] x_p1;
  logic [10:0] y_p1;

  // Clip test: both coordinates must land inside the visible framebuffer.
  function automatic logic on_screen(input logic [10:0] x, input logic [10:0] y);
    return (x < 11'(FB_W)) && (y < 11'(FB_H));
  endfunction

  // Only on-screen pixels are ever written, so 19-bit modular math is exact for them.
  function automatic logic [18:0] linear_addr(input logic [10:0] x, input logic [10:0] y);
    return 19'(y) * 19'(FB_W) + 19'(x);
  endfunction

  assign idx_nxt = idx_p0 + 8'd1;
  assign busy    = (state == READ) || (state == DRAIN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (idx_p0 == 8'hFF) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: sheet address for pixel idx_p0 is presented
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      idx_p0     <= 8'd0;
      drain_cnt  <= 1'b0;
      vld_p1     <= 1'b0;
      fb_we      <= 1'b0;
      sheet_addr <= 16'd0;
      fb_addr    <= 19'd0;
      fb_data    <= 4'd0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == READ);
      case (state)
        IDLE: begin
          if (start) begin
            idx_p0     <= 8'd0;
            sheet_addr <= {src_row, 4'd0, src_col, 4'd0};
          end
        end
        READ: begin
          drain_cnt <= 1'b0;
          if (idx_p0 != 8'hFF) begin
            idx_p0     <= idx_nxt;
            sheet_addr <= {row_q, idx_nxt[7:4], col_q, idx_nxt[3:0]};
          end
        end
        DRAIN:   drain_cnt <= 1'b1;
        default: drain_cnt <= 1'b0;
      endcase
      // Stage p2: palette index arrives, write slot decided
      fb_we <= vld_p1 && (sheet_data != 4'd0) && on_screen(x_p1, y_p1);
      if (vld_p1) begin
        fb_addr <= linear_addr(x_p1, y_p1);
        fb_data <= sheet_data;
      end
    end
  end

  // Stage p1: destination coordinates of the pixel whose data arrives next cycle
  always_ff @(posedge Clk) begin
    if (Reset_n && (state == IDLE) && start) begin
      col_q <= src_col;
      row_q <= src_row;
      dx_q  <= dst_x;
      dy_q  <= dst_y;
    end
    x_p1 <= {1'b0, dx_q} + {7'd0, idx_p0[3:0]};
    y_p1 <= {1'b0, dy_q} + {7'd0, idx_p0[7:4]};
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: table of single-blit scenarios plus
// hand-written reset-abort and back-to-back sequences.
module tb_sprite_blitter;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [3:0]  src_col;
  logic [3:0]  src_row;
  logic [9:0]  dst_x;
  logic [9:0]  dst_y;
  logic [15:0] sheet_addr;
  logic [3:0]  sheet_data;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;

  sprite_blitter dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .src_col(src_col), .src_row(src_row), .dst_x(dst_x), .dst_y(dst_y),
    .sheet_addr(sheet_addr), .sheet_data(sheet_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .busy(busy), .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Spritesheet model: mode 0 opaque 5, mode 1 transparent on even px else 7.
  int mode = 0;
  always @(posedge Clk) begin
    if (mode == 1) sheet_data <= sheet_addr[0] ? 4'd7 : 4'd0;
    else           sheet_data <= 4'd5;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int nwr, first_wr, last_wr, first_fb, last_fb, sheet_first, sheet_last;
  int done_first, done_last, ndone, bad_data, oob, gap_wr, busy_bad, post_bad;

  task automatic run(input logic [3:0] c, input logic [3:0] r, input logic [9:0] x,
                     input logic [9:0] y, input int md, input int ncyc,
                     input int rep_at, input int rst_at, input int again_at);
    int exp_data;
    logic exp_busy;
    nwr = 0; first_wr = -1; last_wr = -1; first_fb = -1; last_fb = -1;
    sheet_first = -1; sheet_last = -1; done_first = -1; done_last = -1;
    ndone = 0; bad_data = 0; oob = 0; gap_wr = 0; busy_bad = 0; post_bad = 0;
    mode = md;
    exp_data = (md == 1) ? 7 : 5;
    @(posedge Clk); #1;
    start = 1'b1; src_col = c; src_row = r; dst_x = x; dst_y = y;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(posedge Clk); #1;
      start = 1'b0;
      Reset_n = 1'b1;
      if (rel == rep_at) begin
        start = 1'b1; src_col = ~c; src_row = ~r; dst_x = 10'd3; dst_y = 10'd4;
      end
      if (rel == rst_at) Reset_n = 1'b0;
      if (rel == again_at) begin
        start = 1'b1; src_col = c; src_row = r; dst_x = x; dst_y = y;
      end
      @(negedge Clk);
      if (fb_we === 1'b1) begin
        nwr++;
        if (first_wr < 0) begin
          first_wr = rel;
          first_fb = int'(fb_addr);
        end
        last_wr = rel;
        last_fb = int'(fb_addr);
        if (int'(fb_data) != exp_data) bad_data++;
        if (int'(fb_addr) >= 307200) oob++;
        if (rel >= 259 && rel <= 262) gap_wr++;
      end
      if (rel == 1)   sheet_first = int'(sheet_addr);
      if (rel == 256) sheet_last  = int'(sheet_addr);
      if (done === 1'b1) begin
        ndone++;
        if (done_first < 0) done_first = rel;
        done_last = rel;
      end
      if (rst_at < 0 && again_at < 0) begin
        exp_busy = (rel >= 1 && rel <= 258);
        if (busy !== exp_busy) busy_bad++;
      end
      if (rst_at >= 0 && rel > rst_at && rel <= again_at + 2) begin
        if (fb_we !== 1'b0 || done !== 1'b0) post_bad++;
        if (rel <= again_at && busy !== 1'b0) post_bad++;
      end
    end
  endtask

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    logic [9:0] x;
    logic [9:0] y;
    int mode;
    int rep_at;
    int nwr;
    int first_wr;
    int last_wr;
    int first_fb;
    int last_fb;
    int sheet_first;
    int sheet_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'd2,  4'd1,  10'd100, 10'd50,  0, -1,  256, 3, 258, 32100,  41715,  'h1020, 'h1F2F};
    vecs[1] = '{4'd2,  4'd1,  10'd100, 10'd50,  1, -1,  128, 4, 258, 32101,  41715,  'h1020, 'h1F2F};
    vecs[2] = '{4'd0,  4'd0,  10'd632, 10'd472, 0, -1,  64,  3, 122, 302712, 307199, 'h0000, 'h0F0F};
    vecs[3] = '{4'd2,  4'd1,  10'd100, 10'd50,  0, 100, 256, 3, 258, 32100,  41715,  'h1020, 'h1F2F};
    vecs[4] = '{4'd15, 4'd15, 10'd0,   10'd0,   0, -1,  256, 3, 258, 0,      9615,   'hF0F0, 'hFFFF};
    vecs[5] = '{4'd3,  4'd4,  10'd640, 10'd0,   0, -1,  0,  -1, -1,  0,      0,      'h4030, 'h4F3F};

    // Reset with start held high: start must be ignored.
    Reset_n = 1'b0; start = 1'b1;
    src_col = 4'hA; src_row = 4'h5; dst_x = 10'd7; dst_y = 10'd9;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1; start = 1'b0;
    @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_sheet_addr", sheet_addr, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    repeat (3) @(negedge Clk);
    chk("start_in_reset_busy", busy, 0);
    chk("start_in_reset_sheet_addr", sheet_addr, 0);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].col, vecs[i].row, vecs[i].x, vecs[i].y, vecs[i].mode, 262,
          vecs[i].rep_at, -1, -1);
      chk($sformatf("v%0d_writes", i), nwr, vecs[i].nwr);
      chk($sformatf("v%0d_first_wr_cycle", i), first_wr, vecs[i].first_wr);
      chk($sformatf("v%0d_last_wr_cycle", i), last_wr, vecs[i].last_wr);
      if (vecs[i].nwr > 0) begin
        chk($sformatf("v%0d_first_fb_addr", i), first_fb, vecs[i].first_fb);
        chk($sformatf("v%0d_last_fb_addr", i), last_fb, vecs[i].last_fb);
      end
      chk($sformatf("v%0d_sheet_first", i), sheet_first, vecs[i].sheet_first);
      chk($sformatf("v%0d_sheet_last", i), sheet_last, vecs[i].sheet_last);
      chk($sformatf("v%0d_done_cycle", i), done_first, 259);
      chk($sformatf("v%0d_done_pulses", i), ndone, 1);
      chk($sformatf("v%0d_bad_fb_data", i), bad_data, 0);
      chk($sformatf("v%0d_out_of_range", i), oob, 0);
      chk($sformatf("v%0d_busy_profile", i), busy_bad, 0);
    end

    // Reset in cycle 120 aborts the blit; restart in cycle 125.
    run(4'd2, 4'd1, 10'd100, 10'd50, 0, 390, -1, 120, 125);
    chk("abort_writes", nwr, 118 + 256);
    chk("abort_quiet_window", post_bad, 0);
    chk("abort_done_pulses", ndone, 1);
    chk("abort_done_cycle", done_first, 384);
    chk("abort_last_wr_cycle", last_wr, 383);
    chk("abort_last_fb_addr", last_fb, 41715);
    chk("abort_bad_fb_data", bad_data, 0);

    // Second start accepted in cycle 260.
    run(4'd2, 4'd1, 10'd100, 10'd50, 0, 522, -1, -1, 260);
    chk("b2b_writes", nwr, 512);
    chk("b2b_done_pulses", ndone, 2);
    chk("b2b_done_first", done_first, 259);
    chk("b2b_done_second", done_last, 519);
    chk("b2b_gap_writes", gap_wr, 0);
    chk("b2b_first_wr_cycle", first_wr, 3);
    chk("b2b_last_wr_cycle", last_wr, 518);
    chk("b2b_last_fb_addr", last_fb, 41715);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
